vga_timing_gen: RTL

Raster timing generator for the 640x480 @ 60 Hz VGA path. Free-running horizontal/vertical counters drive the `DrawX`/`DrawY` pixel coordinates consumed by every sprite/ROM mapper. The block also produces `hs`, `vs` and `blank`, delayed by a programmable number of cycles so they line up with the mappers' registered RGB output. It is the producer end of the `DrawX`/`DrawY`/`blank` interface the mappers read.

---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/vga_timing_gen_if.sv | 30 +++
 rtl/vga_ctl_delay.sv | 48 ++++
 rtl/vga_timing_gen.sv | 110 +++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared constants and types for the VGA raster timing path.
//               Default 640x480@60 porch/sync values, derived line/frame
//               totals, and the packed {hs, vs, blank} control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  // Default 640x480 @ 60 Hz timing (pixel clocks / lines)
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Counters are 10 bits wide; deeper alignment pipes are not supported
  localparam int VGA_MAX_TOTAL = 1024;
  localparam int VGA_MAX_PIPE  = 4;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } vga_ctl_t;

  // Inactive levels: syncs are active-low, blank=1 means visible
  localparam vga_ctl_t VGA_CTL_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Raster bus between the timing generator (master) and the
//               sprite/ROM mappers (slave).
//   DrawX/DrawY  : current pixel coordinates (10 bits each)
//   hs/vs        : active-low syncs, aligned to the mappers' RGB output
//   blank        : 1 = visible pixel, aligned like hs/vs
//   line_start   : one-cycle pulse at DrawX==0
//   frame_start  : one-cycle pulse at DrawX==0, DrawY==0
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       hs;
  logic       vs;
  logic       blank;
  logic       line_start;
  logic       frame_start;

  modport master (
    output DrawX, DrawY, hs, vs, blank, line_start, frame_start
  );

  modport slave (
    input  DrawX, DrawY, hs, vs, blank, line_start, frame_start
  );
endinterface : vga_timing_gen_if
`default_nettype wire

// File: rtl/vga_ctl_delay.sv
`default_nettype none
// ============================================================================
// Module      : vga_ctl_delay
// Description : PIPE_DELAY-deep shift register for the {hs, vs, blank}
//               bundle. Every stage resets to the idle levels. Depth 0 is a
//               plain wire.
//   clk    : pixel clock
//   rst    : synchronous, active-high
//   i_ctl  : raw control bundle
//   o_ctl  : control bundle delayed by PIPE_DELAY cycles
// Revision    : 1.0 - initial release
// ============================================================================
module vga_ctl_delay
  import vga_timing_pkg::*;
#(
  parameter int PIPE_DELAY = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  vga_ctl_t i_ctl,
  output vga_ctl_t o_ctl
);

  generate
    if (PIPE_DELAY == 0) begin : g_pass
      assign o_ctl = i_ctl;
    end else begin : g_pipe
      vga_ctl_t r_stage [PIPE_DELAY];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < PIPE_DELAY; i++) begin
            r_stage[i] <= VGA_CTL_IDLE;
          end
        end else begin
          r_stage[0] <= i_ctl;
          for (int i = 1; i < PIPE_DELAY; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign o_ctl = r_stage[PIPE_DELAY-1];
    end
  endgenerate

endmodule : vga_ctl_delay
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Free-running VGA raster timing generator. Horizontal and
//               vertical counters drive DrawX/DrawY directly; hs/vs/blank
//               are decoded from the counters and delayed PIPE_DELAY cycles
//               to line up with the mappers' registered RGB.
//   vga_clk : pixel clock (only clock)
//   reset   : synchronous, active-high
//   vif     : raster bus master (DrawX, DrawY, hs, vs, blank,
//             line_start, frame_start)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int PIPE_DELAY = 2
) (
  input  logic             vga_clk,
  input  logic             reset,
  vga_timing_gen_if.master vif
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (c_H_TOTAL > VGA_MAX_TOTAL || c_V_TOTAL > VGA_MAX_TOTAL) begin : g_bad_total
      $error("vga_timing_gen: H/V total exceeds 1024");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > VGA_MAX_PIPE) begin : g_bad_pipe
      $error("vga_timing_gen: PIPE_DELAY must be 0..4");
    end
  endgenerate

  localparam logic [9:0]  c_H_LAST   = 10'(c_H_TOTAL - 1);
  localparam logic [9:0]  c_V_LAST   = 10'(c_V_TOTAL - 1);
  // Decode bounds are 11 bits so an end value of exactly 1024 stays exact
  localparam logic [10:0] c_H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] c_HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] c_V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] c_VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] c_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  r_hc;
  logic [9:0]  r_vc;
  logic        w_h_last;
  logic        w_v_last;
  logic [10:0] w_hc_ext;
  logic [10:0] w_vc_ext;
  vga_ctl_t    w_raw;
  vga_ctl_t    w_ctl;

  assign w_h_last = (r_hc == c_H_LAST);
  assign w_v_last = (r_vc == c_V_LAST);
  assign w_hc_ext = {1'b0, r_hc};
  assign w_vc_ext = {1'b0, r_vc};

  // vc only moves on the hc wrap, so the frame wrap lands on (0,0) together
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (w_h_last) begin
      r_hc <= '0;
      r_vc <= w_v_last ? '0 : r_vc + 10'd1;
    end else begin
      r_hc <= r_hc + 10'd1;
    end
  end

  // Raw decode is forced idle during reset so the depth-0 path also shows
  // the inactive levels while reset is held
  always_comb begin
    w_raw = VGA_CTL_IDLE;
    if (!reset) begin
      w_raw.hs    = !((w_hc_ext >= c_HS_START) && (w_hc_ext < c_HS_END));
      w_raw.vs    = !((w_vc_ext >= c_VS_START) && (w_vc_ext < c_VS_END));
      w_raw.blank = (w_hc_ext < c_H_ACT) && (w_vc_ext < c_V_ACT);
    end
  end

  vga_ctl_delay #(
    .PIPE_DELAY (PIPE_DELAY)
  ) u_ctl_delay (
    .clk   (vga_clk),
    .rst   (reset),
    .i_ctl (w_raw),
    .o_ctl (w_ctl)
  );

  assign vif.DrawX       = r_hc;
  assign vif.DrawY       = r_vc;
  assign vif.hs          = w_ctl.hs;
  assign vif.vs          = w_ctl.vs;
  assign vif.blank       = w_ctl.blank;
  assign vif.line_start  = !reset && (r_hc == 10'd0);
  assign vif.frame_start = !reset && (r_hc == 10'd0) && (r_vc == 10'd0);

endmodule : vga_timing_gen
`default_nettype wire
